// File: rtl/mul_seq.sv
// ============================================================================
// Module   : mul_seq
// Purpose  : Iterative shift-and-add multiplier for RV32M MUL/MULH/MULHSU/
//            MULHU. One WIDTH-bit add per cycle, fixed WIDTH+2 cycle latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic [1:0]       funct_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [1:0] c_funct_mul    = 2'b00;
  localparam logic [1:0] c_funct_mulh   = 2'b01;
  localparam logic [1:0] c_funct_mulhsu = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_NEG  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                 r_state;
  logic [WIDTH-1:0]       r_mcand;
  logic [WIDTH-1:0]       r_mplier;
  logic [2*WIDTH-1:0]     r_prod;
  logic [CW-1:0]          r_cnt;
  logic                   r_neg;
  logic [1:0]             r_funct;
  logic                   r_busy;
  logic                   r_done;
  logic [WIDTH-1:0]       r_result;

  logic                   w_a_neg;
  logic                   w_b_neg;
  logic [WIDTH-1:0]       w_mag_a;
  logic [WIDTH-1:0]       w_mag_b;
  logic [WIDTH-1:0]       w_addend;
  logic [WIDTH:0]         w_sum;
  logic [2*WIDTH-1:0]     w_final;

  // Operand sign handling for acceptance, the single add of a CALC step,
  // and the optionally negated final product.
  always_comb begin
    w_a_neg  = ((funct_i == c_funct_mulh) || (funct_i == c_funct_mulhsu)) && op_a_i[WIDTH-1];
    w_b_neg  = (funct_i == c_funct_mulh) && op_b_i[WIDTH-1];
    w_mag_a  = w_a_neg ? (~op_a_i + WIDTH'(1)) : op_a_i;
    w_mag_b  = w_b_neg ? (~op_b_i + WIDTH'(1)) : op_b_i;
    w_addend = r_mplier[0] ? r_mcand : '0;
    w_sum    = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
    w_final  = r_neg ? (~r_prod + (2*WIDTH)'(1)) : r_prod;
  end

  // Sequencer FSM: reset, then flush, then the per-state datapath updates.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_funct  <= 2'b00;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else if (flush_i) begin
      // Abort: drop back to IDLE silently, the last result stays visible.
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start_i) begin
            r_mcand  <= w_mag_a;
            r_mplier <= w_mag_b;
            r_neg    <= w_a_neg ^ w_b_neg;
            r_funct  <= funct_i;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_CALC;
          end
        end
        S_CALC: begin
          // Carry out of the add lands in the top bit after the shift.
          r_prod   <= {w_sum, r_prod[WIDTH-1:1]};
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_state <= S_NEG;
          end
        end
        S_NEG: begin
          r_prod   <= w_final;
          r_result <= (r_funct == c_funct_mul) ? w_final[WIDTH-1:0]
                                               : w_final[2*WIDTH-1:WIDTH];
          r_done   <= 1'b1;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o   = r_busy;
  assign done_o   = r_done;
  assign result_o = r_result;

endmodule

`default_nettype wire

// File: tb/tb_mul_seq.sv
// ============================================================================
// Module   : tb_mul_seq
// Purpose  : Scoreboard bench for mul_seq: expected result and completion
//            cycle are queued at start, checked when done_o pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         start_i = 1'b0;
  logic         flush_i = 1'b0;
  logic [1:0]   funct_i = 2'b00;
  logic [W-1:0] op_a_i = '0;
  logic [W-1:0] op_b_i = '0;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] result_o;

  typedef struct {
    logic [W-1:0] res;
    int           cyc;
  } exp_t;

  exp_t q_exp[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_done = 0;

  mul_seq #(.WIDTH(W)) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .flush_i  (flush_i),
    .funct_i  (funct_i),
    .op_a_i   (op_a_i),
    .op_b_i   (op_b_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;

  // Cycle index: a value N means the interval after the N-th rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Independent reference: full-width signed multiply in plain arithmetic.
  function automatic logic [W-1:0] model(input logic [1:0] f, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic signed [2*W+1:0] sa, sb, p;
    sa = (f == 2'b01 || f == 2'b10) ? {{(W+2){a[W-1]}}, a} : {{(W+2){1'b0}}, a};
    sb = (f == 2'b01) ? {{(W+2){b[W-1]}}, b} : {{(W+2){1'b0}}, b};
    p  = sa * sb;
    return (f == 2'b00) ? p[W-1:0] : p[2*W-1:W];
  endfunction

  // Scoreboard consumer: every done_o must match the oldest queued entry.
  always @(negedge clk) begin
    if (!rst_i && done_o) begin
      n_done++;
      if (q_exp.size() == 0) begin
        check("spurious_done", 64'(cyc), 64'(0));
      end else begin
        exp_t e;
        e = q_exp.pop_front();
        check("result", 64'(result_o), 64'(e.res));
        check("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    funct_i = f;
    op_a_i  = a;
    op_b_i  = b;
  endtask

  // Issue one multiply in the current cycle; returns after the accept edge.
  task automatic do_mul(input logic [1:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp);
    exp_t e;
    drive(f, a, b);
    start_i = 1'b1;
    e.res = exp;
    e.cyc = cyc + W + 2;
    q_exp.push_back(e);
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (q_exp.size() != 0 && k < 80) begin
      tick();
      k++;
    end
    if (q_exp.size() != 0) begin
      check("timeout_pending", 64'(q_exp.size()), 64'(0));
      q_exp.delete();
    end
    tick();
    tick();
  endtask

  initial begin
    int c0;
    int d0;
    logic [1:0]   rf;
    logic [W-1:0] ra, rb;

    repeat (3) tick();
    rst_i = 1'b0;
    check("reset_busy", 64'(busy_o), 64'(0));
    check("reset_done", 64'(done_o), 64'(0));
    check("reset_result", 64'(result_o), 64'(0));
    tick();

    // Directed cases from the corner-value list.
    do_mul(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE); wait_idle();
    do_mul(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001); wait_idle();
    do_mul(2'b01, 32'h80000000, 32'h80000000, 32'h40000000); wait_idle();
    do_mul(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000); wait_idle();
    do_mul(2'b00, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB); wait_idle();
    do_mul(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF); wait_idle();
    do_mul(2'b01, 32'h00000000, 32'hDEADBEEF, 32'h00000000); wait_idle();
    do_mul(2'b00, 32'h00000000, 32'h12345678, 32'h00000000); wait_idle();

    // Random operands against the arithmetic model.
    for (int i = 0; i < 8; i++) begin
      rf = 2'($urandom_range(0, 3));
      ra = $urandom();
      rb = $urandom();
      do_mul(rf, ra, rb, model(rf, ra, rb));
      wait_idle();
    end

    // Starts while busy are ignored; back-to-back start right after DONE.
    c0 = cyc;
    do_mul(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    check("busy_after_accept", 64'(busy_o), 64'(1));
    repeat (4) tick();
    drive(2'b00, 32'h11111111, 32'h22222222);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    while (cyc < c0 + W + 2) tick();
    check("busy_in_done", 64'(busy_o), 64'(1));
    drive(2'b00, 32'h33333333, 32'h44444444);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("busy_after_done", 64'(busy_o), 64'(0));
    do_mul(2'b00, 32'd3, 32'd5, 32'd15);
    wait_idle();
    check("b2b_pending", 64'(q_exp.size()), 64'(0));

    // Flush mid-operation: no done, result kept.
    d0 = n_done;
    c0 = cyc;
    drive(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    while (cyc < c0 + 10) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("flush_busy", 64'(busy_o), 64'(0));
    check("flush_result", 64'(result_o), 64'(15));
    repeat (45) tick();
    check("flush_no_done", 64'(n_done), 64'(d0));

    // Flush together with start in IDLE: not accepted.
    drive(2'b00, 32'd9, 32'd9);
    start_i = 1'b1;
    flush_i = 1'b1;
    tick();
    start_i = 1'b0;
    flush_i = 1'b0;
    check("flush_start_busy", 64'(busy_o), 64'(0));
    repeat (45) tick();
    check("flush_start_no_done", 64'(n_done), 64'(d0));
    check("flush_start_result", 64'(result_o), 64'(15));

    // Reset mid-operation, then a fresh multiply at full latency.
    c0 = cyc;
    drive(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    while (cyc < c0 + 20) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_done", 64'(done_o), 64'(0));
    check("rst_result", 64'(result_o), 64'(0));
    do_mul(2'b00, 32'd3, 32'd5, 32'd15);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
